// File: rtl/arq_receiver.sv
// Go-back-N ARQ receive side: forwards only the next in-order frame through a
// 2-entry output skid FIFO and returns coalesced cumulative acknowledgements.
module arq_receiver #(
    parameter int SEQ_BITS  = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEQ_BITS-1:0]  in_payload_seq,
    input  logic [DATA_BITS-1:0] in_payload_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_payload,
    output logic                 ack_valid,
    input  logic                 ack_ready,
    output logic [SEQ_BITS-1:0]  ack_payload_seq
);

    logic [SEQ_BITS-1:0]  expected_r;
    logic [1:0]           count_r;
    logic                 rd_ptr_r;
    logic                 wr_ptr_r;
    logic [DATA_BITS-1:0] mem_r [0:1];
    logic                 ack_pending_r;

    logic [SEQ_BITS-1:0]  dist_s;
    logic                 in_fire_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 ack_fire_s;
    logic [1:0]           count_nxt_s;
    logic                 ack_pending_nxt_s;

    // in_ready looks only at registered occupancy, so no path from out/ack ready.
    assign in_ready        = ~rst && (count_r < 2'd2);
    assign out_valid       = (count_r != 2'd0);
    assign out_payload     = mem_r[rd_ptr_r];
    assign ack_valid       = ack_pending_r;
    assign ack_payload_seq = expected_r;

    // Handshake decode; duplicates and ahead-of-window frames both have nonzero distance and are dropped.
    always_comb begin
        dist_s     = in_payload_seq - expected_r;
        in_fire_s  = in_valid && in_ready;
        push_s     = in_fire_s && (dist_s == {SEQ_BITS{1'b0}});
        pop_s      = out_valid && out_ready;
        ack_fire_s = ack_valid && ack_ready;
    end

    // Next occupancy and ack-pending state.
    always_comb begin
        count_nxt_s       = count_r;
        ack_pending_nxt_s = ack_pending_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
        // A new frame in the same cycle as an ack handshake keeps the ack owed.
        if (in_fire_s) begin
            ack_pending_nxt_s = 1'b1;
        end else if (ack_fire_s) begin
            ack_pending_nxt_s = 1'b0;
        end else begin
            ack_pending_nxt_s = ack_pending_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            expected_r    <= {SEQ_BITS{1'b0}};
            count_r       <= 2'd0;
            rd_ptr_r      <= 1'b0;
            wr_ptr_r      <= 1'b0;
            mem_r[0]      <= {DATA_BITS{1'b0}};
            mem_r[1]      <= {DATA_BITS{1'b0}};
            ack_pending_r <= 1'b0;
        end else begin
            count_r       <= count_nxt_s;
            ack_pending_r <= ack_pending_nxt_s;
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_payload_p;
                wr_ptr_r        <= ~wr_ptr_r;
                expected_r      <= expected_r + {{(SEQ_BITS-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
        end
    end

endmodule

// File: tb/tb_arq_receiver.sv
// Directed self-checking bench for arq_receiver (SEQ_BITS=4, DATA_BITS=8).
module tb_arq_receiver;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_payload_seq;
    logic [7:0] in_payload_p;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_payload;
    logic       ack_valid;
    logic       ack_ready;
    logic [3:0] ack_payload_seq;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] got_q [$];
    logic [3:0] ack_q [$];
    int stall_cnt;

    arq_receiver #(.SEQ_BITS(4), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_payload_seq(in_payload_seq), .in_payload_p(in_payload_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .ack_valid(ack_valid), .ack_ready(ack_ready), .ack_payload_seq(ack_payload_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change just after the rising edge, so the falling edge sees what the next edge will take.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got_q.push_back(out_payload);
        if (!rst && ack_valid && ack_ready) ack_q.push_back(ack_payload_seq);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        got_q.delete();
        ack_q.delete();
    endtask

    // Present a frame, wait (bounded) for in_ready, then take one edge; in_valid is left high.
    task automatic send(input logic [3:0] seq, input logic [7:0] data);
        int n;
        in_valid = 1'b1;
        in_payload_seq = seq;
        in_payload_p = data;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) check_eq("send_timeout", 32'd0, 32'd1);
        step();
    endtask

    initial begin
        logic [3:0] s;
        rst = 1'b1;
        in_valid = 1'b0;
        in_payload_seq = 4'd0;
        in_payload_p = 8'd0;
        out_ready = 1'b0;
        ack_ready = 1'b0;

        // Reset state
        step();
        step();
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_ack_valid", ack_valid, 1'b0);
        rst = 1'b0;
        step();
        check_eq("post_rst_in_ready", in_ready, 1'b1);
        check_eq("post_rst_out_valid", out_valid, 1'b0);
        check_eq("post_rst_ack_valid", ack_valid, 1'b0);
        check_eq("post_rst_expected", ack_payload_seq, 4'd0);

        // In-order burst 0..15, 0..3
        got_q.delete();
        ack_q.delete();
        out_ready = 1'b1;
        ack_ready = 1'b1;
        stall_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            s = 4'(i);
            send(s, 8'(i * 3 + 1));
            if (i == 0) begin
                check_eq("burst_lat_valid", out_valid, 1'b1);
                check_eq("burst_lat_data", out_payload, 8'd1);
            end
            if (!in_ready) stall_cnt++;
        end
        in_valid = 1'b0;
        step();
        step();
        check_eq("burst_no_stall", stall_cnt, 0);
        check_eq("burst_count", got_q.size(), 20);
        for (int i = 0; i < 20 && i < got_q.size(); i++)
            check_eq($sformatf("burst_data%0d", i), got_q[i], 8'(i * 3 + 1));
        check_eq("burst_ack_seq", ack_payload_seq, 4'd4);
        check_eq("burst_last_ack", (ack_q.size() > 0) ? ack_q[ack_q.size()-1] : 4'hF, 4'd4);
        check_eq("burst_ack_idle", ack_valid, 1'b0);

        // Duplicate
        do_reset();
        send(4'd0, 8'h10);
        send(4'd1, 8'h11);
        send(4'd2, 8'h12);
        in_valid = 1'b0;
        step();
        step();
        step();
        check_eq("dup_pre_count", got_q.size(), 3);
        got_q.delete();
        ack_q.delete();
        send(4'd1, 8'h55);
        in_valid = 1'b0;
        check_eq("dup_ack_valid", ack_valid, 1'b1);
        check_eq("dup_ack_seq", ack_payload_seq, 4'd3);
        step();
        step();
        check_eq("dup_no_out", got_q.size(), 0);
        check_eq("dup_ack_cnt", ack_q.size(), 1);
        check_eq("dup_ack_q", (ack_q.size() > 0) ? ack_q[0] : 4'hF, 4'd3);

        // Gap: 0,2,3 then 1,2,3
        do_reset();
        send(4'd0, 8'h20);
        send(4'd2, 8'hEE);
        send(4'd3, 8'hEF);
        in_valid = 1'b0;
        step();
        check_eq("gap_mid_ack", ack_payload_seq, 4'd1);
        check_eq("gap_mid_count", got_q.size(), 1);
        send(4'd1, 8'h21);
        send(4'd2, 8'h22);
        send(4'd3, 8'h23);
        in_valid = 1'b0;
        step();
        step();
        check_eq("gap_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check_eq($sformatf("gap_data%0d", i), got_q[i], 8'(8'h20 + i));
        check_eq("gap_ack_seq", ack_payload_seq, 4'd4);
        check_eq("gap_last_ack", (ack_q.size() > 0) ? ack_q[ack_q.size()-1] : 4'hF, 4'd4);

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        send(4'd0, 8'h30);
        send(4'd1, 8'h31);
        in_payload_seq = 4'd2;
        in_payload_p = 8'h32;
        check_eq("bp_in_ready_low", in_ready, 1'b0);
        step();
        step();
        step();
        check_eq("bp_still_low", in_ready, 1'b0);
        check_eq("bp_out_valid", out_valid, 1'b1);
        check_eq("bp_head_stable", out_payload, 8'h30);
        check_eq("bp_expected", ack_payload_seq, 4'd2);
        out_ready = 1'b1;
        step();
        check_eq("bp_ready_back", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        check_eq("bp_count", got_q.size(), 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++)
            check_eq($sformatf("bp_data%0d", i), got_q[i], 8'(8'h30 + i));

        // Ack coalescing
        do_reset();
        out_ready = 1'b1;
        ack_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(4'(i), 8'(8'h40 + i));
            check_eq($sformatf("coal_valid%0d", i), ack_valid, 1'b1);
            check_eq($sformatf("coal_seq%0d", i), ack_payload_seq, 4'(i + 1));
        end
        in_valid = 1'b0;
        step();
        check_eq("coal_held", ack_valid, 1'b1);
        ack_q.delete();
        ack_ready = 1'b1;
        step();
        ack_ready = 1'b0;
        check_eq("coal_cleared", ack_valid, 1'b0);
        step();
        check_eq("coal_ack_cnt", ack_q.size(), 1);
        check_eq("coal_ack_seq", (ack_q.size() > 0) ? ack_q[0] : 4'hF, 4'd5);

        // Reset mid-stream
        do_reset();
        out_ready = 1'b0;
        ack_ready = 1'b0;
        send(4'd0, 8'h50);
        send(4'd1, 8'h51);
        in_payload_seq = 4'd2;
        in_payload_p = 8'h52;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        check_eq("mrst_out_valid", out_valid, 1'b0);
        check_eq("mrst_ack_valid", ack_valid, 1'b0);
        check_eq("mrst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        step();
        check_eq("mrst_after_out", out_valid, 1'b0);
        check_eq("mrst_after_ack", ack_valid, 1'b0);
        got_q.delete();
        out_ready = 1'b1;
        ack_ready = 1'b1;
        send(4'd0, 8'h77);
        check_eq("mrst_seq0_valid", out_valid, 1'b1);
        check_eq("mrst_seq0_data", out_payload, 8'h77);
        send(4'd3, 8'h33);
        in_valid = 1'b0;
        step();
        step();
        check_eq("mrst_count", got_q.size(), 1);
        check_eq("mrst_data", (got_q.size() > 0) ? got_q[0] : 8'h00, 8'h77);
        check_eq("mrst_ack_seq", ack_payload_seq, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
